// File: rtl/sar_ctrl_if.sv
// Analogue/digital boundary of the SAR ADC: comparator clock, sampling, cap-array
// switches, comparator decision and ready flag. master = controller, slave = analogue.
interface sar_ctrl_if #(
    parameter int NSTEP = 8
);
    logic             ms_sar_clock;
    logic             ms_sar_sample;
    logic [NSTEP-1:0] ms_sar_sw;
    logic [NSTEP-1:0] ms_sar_swb;
    logic             ms_sar_dh;
    logic             ms_sar_dl;
    logic             ms_sar_rdy;

    modport master (
        output ms_sar_clock, ms_sar_sample, ms_sar_sw, ms_sar_swb,
        input  ms_sar_dh, ms_sar_dl, ms_sar_rdy
    );

    modport slave (
        input  ms_sar_clock, ms_sar_sample, ms_sar_sw, ms_sar_swb,
        output ms_sar_dh, ms_sar_dl, ms_sar_rdy
    );
endinterface

// File: rtl/sar_ctrl.sv
// Successive-approximation controller: sample, binary search over NSTEP bits, report code.
// Optional break-before-make GAP state between code changes: define SAR_BBM_EN.
module sar_ctrl #(
    parameter int NSTEP   = 8,
    parameter int NSAMPLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    sar_ctrl_if.master       sar,
    output logic             busy,
    output logic [NSTEP-1:0] data,
    output logic             data_valid,
    output logic             err
);
    localparam int CW = (NSAMPLE > 1) ? $clog2(NSAMPLE) : 1;
    localparam int IW = $clog2(NSTEP);
    localparam logic [CW-1:0]    CNT_LAST = CW'(NSAMPLE - 1);
    localparam logic [IW-1:0]    IDX_MSB  = IW'(NSTEP - 1);
    localparam logic [NSTEP-1:0] MSB_CODE = {1'b1, {(NSTEP-1){1'b0}}};

`ifdef SAR_BBM_EN
    typedef enum logic [2:0] {IDLE, SAMP_HI, SAMP_LO, CMP_HI, CMP_LO, DONE, GAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, SAMP_HI, SAMP_LO, CMP_HI, CMP_LO, DONE} state_t;
`endif

    state_t           r_state;
    logic [NSTEP-1:0] r_code;
    logic [NSTEP-1:0] r_sw;
    logic [NSTEP-1:0] r_swb;
    logic [NSTEP-1:0] r_data;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cnt;
    logic             r_clock;
    logic             r_sample;
    logic             r_dh;
    logic             r_dl;
    logic             r_busy;
    logic             r_valid;
    logic             r_err;

    logic [NSTEP-1:0] w_trial;
    logic [NSTEP-1:0] w_next_code;
    logic             w_err;

    // Resolve the current bit from the captured decision and raise the next trial bit.
    // dh == dl is an invalid decision: the bit is forced to 0 (dl & ~dh covers both cases).
    always_comb begin
        w_trial = r_code;
        w_trial[r_idx] = r_dl & ~r_dh;
        if (r_idx != '0)
            w_trial[r_idx - IW'(1)] = 1'b1;
        w_next_code = (r_state == SAMP_LO) ? MSB_CODE : w_trial;
    end

    assign w_err = (r_dh == r_dl);

`ifdef SAR_BBM_EN
    logic [NSTEP-1:0] w_diff;
    logic [NSTEP-1:0] w_gap_sw;
    logic [NSTEP-1:0] w_gap_swb;

    // Bits about to toggle open both switches for one cycle; stable bits hold.
    assign w_diff    = r_code ^ w_next_code;
    assign w_gap_sw  = r_code & ~w_diff;
    assign w_gap_swb = ~r_code & ~w_diff;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_code   <= '0;
            r_sw     <= '0;
            r_swb    <= '1;
            r_data   <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_clock  <= 1'b0;
            r_sample <= 1'b0;
            r_dh     <= 1'b0;
            r_dl     <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && sar.ms_sar_rdy) begin
                        r_state  <= SAMP_HI;
                        r_code   <= '0;
                        r_sw     <= '0;
                        r_swb    <= '1;
                        r_err    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_clock  <= 1'b1;
                        r_sample <= 1'b1;
                    end
                end
                SAMP_HI: begin
                    r_clock <= 1'b0;
                    r_state <= SAMP_LO;
                end
                SAMP_LO: begin
                    if (r_cnt != CNT_LAST) begin
                        r_cnt   <= r_cnt + CW'(1);
                        r_clock <= 1'b1;
                        r_state <= SAMP_HI;
                    end else begin
                        r_sample <= 1'b0;
                        r_idx    <= IDX_MSB;
                        r_code   <= w_next_code;
`ifdef SAR_BBM_EN
                        r_sw     <= w_gap_sw;
                        r_swb    <= w_gap_swb;
                        r_state  <= GAP;
`else
                        r_sw     <= w_next_code;
                        r_swb    <= ~w_next_code;
                        r_clock  <= 1'b1;
                        r_state  <= CMP_HI;
`endif
                    end
                end
                CMP_HI: begin
                    r_dh    <= sar.ms_sar_dh;
                    r_dl    <= sar.ms_sar_dl;
                    r_clock <= 1'b0;
                    r_state <= CMP_LO;
                end
                CMP_LO: begin
                    if (w_err)
                        r_err <= 1'b1;
                    r_code <= w_next_code;
                    if (r_idx != '0) begin
                        r_idx   <= r_idx - IW'(1);
`ifdef SAR_BBM_EN
                        r_sw    <= w_gap_sw;
                        r_swb   <= w_gap_swb;
                        r_state <= GAP;
`else
                        r_sw    <= w_next_code;
                        r_swb   <= ~w_next_code;
                        r_clock <= 1'b1;
                        r_state <= CMP_HI;
`endif
                    end else begin
                        r_sw    <= w_next_code;
                        r_swb   <= ~w_next_code;
                        r_data  <= w_next_code;
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
`ifdef SAR_BBM_EN
                GAP: begin
                    r_sw    <= r_code;
                    r_swb   <= ~r_code;
                    r_clock <= 1'b1;
                    r_state <= CMP_HI;
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    assign sar.ms_sar_clock  = r_clock;
    assign sar.ms_sar_sample = r_sample;
    assign sar.ms_sar_sw     = r_sw;
    assign sar.ms_sar_swb    = r_swb;
    assign busy              = r_busy;
    assign data              = r_data;
    assign data_valid        = r_valid;
    assign err               = r_err;
endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl with an ideal comparator (dl = trial code <= target).
module tb_sar_ctrl;
`ifdef SAR_BBM_EN
    localparam int LAT = 27;
`else
    localparam int LAT = 19;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rdy = 1'b1;
    logic       force_en = 1'b0;
    logic [7:0] target = 8'h00;
    logic       busy, data_valid, err;
    logic [7:0] data;
    logic       w_force, w_le;

    int n_checks = 0;
    int n_errors = 0;
    int clk_edges = 0;
    logic [7:0] log_sw [0:100];
    logic [7:0] log_swb [0:100];

    sar_ctrl_if #(.NSTEP(8)) sif ();

    sar_ctrl #(.NSTEP(8), .NSAMPLE(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sar        (sif.master),
        .busy       (busy),
        .data       (data),
        .data_valid (data_valid),
        .err        (err)
    );

    // Force an invalid decision only on the bit-5 trial of an all-ones target.
    assign w_force        = force_en && (sif.ms_sar_sw == 8'hE0);
    assign w_le           = (sif.ms_sar_sw <= target);
    assign sif.ms_sar_dl  = w_force ? 1'b0 : w_le;
    assign sif.ms_sar_dh  = w_force ? 1'b0 : ~w_le;
    assign sif.ms_sar_rdy = rdy;

    always #5 clk = ~clk;
    always @(posedge sif.ms_sar_clock) clk_edges++;

    task automatic do_conv(input logic [7:0] tgt, output int lat, output logic [7:0] res,
                           output int busy_n, output int samp_n, output int ovl, output int edges);
        int e0;
        lat = -1; res = 8'hxx; busy_n = 0; samp_n = 0; ovl = 0;
        target = tgt;
        @(negedge clk);
        start = 1'b1;
        e0 = clk_edges;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            log_sw[n]  = sif.ms_sar_sw;
            log_swb[n] = sif.ms_sar_swb;
            if (busy) busy_n++;
            if (sif.ms_sar_sample) samp_n++;
            if ((sif.ms_sar_sw & sif.ms_sar_swb) != 8'h00) ovl++;
            if (data_valid) begin
                lat = n;
                res = data;
                break;
            end
        end
        edges = clk_edges - e0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({sif.ms_sar_clock, sif.ms_sar_sample, busy, data_valid, err} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {sif.ms_sar_clock, sif.ms_sar_sample, busy, data_valid, err});
        end
        n_checks++;
        if ({sif.ms_sar_sw, sif.ms_sar_swb, data} !== 24'h00FF00) begin
            n_errors++;
            $display("FAIL reset_vectors: got %h expected 00ff00", {sif.ms_sar_sw, sif.ms_sar_swb, data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int lat, bn, sn, ov, ed;
        logic [7:0] res;
        do_conv(8'hA5, lat, res, bn, sn, ov, ed);
        n_checks++;
        if (res !== 8'hA5) begin n_errors++; $display("FAIL basic_data: got %h expected a5", res); end
        n_checks++;
        if (lat != LAT) begin n_errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
        n_checks++;
        if (bn != LAT) begin n_errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bn, LAT); end
        n_checks++;
        if (sn != 2) begin n_errors++; $display("FAIL basic_sample_cycles: got %0d expected 2", sn); end
        n_checks++;
        if (ed != 9) begin n_errors++; $display("FAIL basic_clock_pulses: got %0d expected 9", ed); end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL basic_err: got %b expected 0", err); end
        @(negedge clk);
        n_checks++;
        if ({data_valid, busy} !== 2'b00) begin
            n_errors++;
            $display("FAIL basic_after_done: got dv/busy %b expected 00", {data_valid, busy});
        end
        n_checks++;
        if (data !== 8'hA5) begin n_errors++; $display("FAIL basic_data_held: got %h expected a5", data); end
    endtask

    task automatic test_back_to_back();
        int dv1 = -1, dv2 = -1, ovl = 0, idle_busy = -1;
        logic [7:0] r1 = 8'hxx, r2 = 8'hxx;
        target = 8'h00;
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if ((sif.ms_sar_sw & sif.ms_sar_swb) != 8'h00) ovl++;
            if (dv1 > 0 && n == dv1 + 1) idle_busy = int'(busy);
            if (data_valid) begin
                if (dv1 < 0) begin
                    dv1 = n; r1 = data; target = 8'hFF;
                end else begin
                    dv2 = n; r2 = data; break;
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (r1 !== 8'h00) begin n_errors++; $display("FAIL b2b_first: got %h expected 00", r1); end
        n_checks++;
        if (r2 !== 8'hFF) begin n_errors++; $display("FAIL b2b_second: got %h expected ff", r2); end
        n_checks++;
        if (dv2 - dv1 != LAT + 1) begin
            n_errors++; $display("FAIL b2b_spacing: got %0d expected %0d", dv2 - dv1, LAT + 1);
        end
        n_checks++;
        if (idle_busy != 0) begin n_errors++; $display("FAIL b2b_idle_gap: busy got %0d expected 0", idle_busy); end
        n_checks++;
        if (ovl != 0) begin n_errors++; $display("FAIL b2b_sw_overlap: got %0d cycles expected 0", ovl); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_err();
        int lat, bn, sn, ov, ed;
        logic [7:0] res;
        force_en = 1'b1;
        do_conv(8'hFF, lat, res, bn, sn, ov, ed);
        force_en = 1'b0;
        n_checks++;
        if (res !== 8'hDF) begin n_errors++; $display("FAIL err_data: got %h expected df", res); end
        n_checks++;
        if (err !== 1'b1) begin n_errors++; $display("FAIL err_flag: got %b expected 1", err); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (err !== 1'b1) begin n_errors++; $display("FAIL err_sticky: got %b expected 1", err); end
        do_conv(8'hFF, lat, res, bn, sn, ov, ed);
        n_checks++;
        if (res !== 8'hFF) begin n_errors++; $display("FAIL err_recover_data: got %h expected ff", res); end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL err_cleared: got %b expected 0", err); end
        @(negedge clk);
    endtask

    task automatic test_rdy();
        int lat, bn, sn, ov, ed, e0, bad = 0;
        logic [7:0] res;
        rdy = 1'b0;
        e0 = clk_edges;
        @(negedge clk);
        start = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (busy || sif.ms_sar_sample) bad++;
        end
        start = 1'b0;
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL rdy_busy: got %0d busy cycles expected 0", bad); end
        n_checks++;
        if (clk_edges != e0) begin
            n_errors++; $display("FAIL rdy_clock: got %0d pulses expected 0", clk_edges - e0);
        end
        rdy = 1'b1;
        do_conv(8'h3C, lat, res, bn, sn, ov, ed);
        n_checks++;
        if (res !== 8'h3C || lat != LAT) begin
            n_errors++; $display("FAIL rdy_conv: got %h at %0d expected 3c at %0d", res, lat, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int lat, bn, sn, ov, ed, hit = 0;
        logic [7:0] res;
        target = 8'hA5;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (sif.ms_sar_clock && sif.ms_sar_sw == 8'hA8) begin hit = 1; break; end
        end
        n_checks++;
        if (hit != 1) begin n_errors++; $display("FAIL arst_reach_bit3: got %0d expected 1", hit); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sif.ms_sar_clock, sif.ms_sar_sample, busy, data_valid, err} !== 5'b0) begin
            n_errors++;
            $display("FAIL arst_flags: got %b expected 00000",
                     {sif.ms_sar_clock, sif.ms_sar_sample, busy, data_valid, err});
        end
        n_checks++;
        if ({sif.ms_sar_sw, sif.ms_sar_swb, data} !== 24'h00FF00) begin
            n_errors++;
            $display("FAIL arst_vectors: got %h expected 00ff00", {sif.ms_sar_sw, sif.ms_sar_swb, data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_conv(8'hA5, lat, res, bn, sn, ov, ed);
        n_checks++;
        if (res !== 8'hA5 || lat != LAT) begin
            n_errors++; $display("FAIL arst_recover: got %h at %0d expected a5 at %0d", res, lat, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_pattern_5a();
        int lat, bn, sn, ov, ed;
        logic [7:0] res;
`ifdef SAR_BBM_EN
        logic [7:0] exp_sw  [0:7] = '{8'h00, 8'h00, 8'h40, 8'h40, 8'h50, 8'h58, 8'h58, 8'h5A};
        logic [7:0] exp_swb [0:7] = '{8'h7F, 8'h3F, 8'h9F, 8'h8F, 8'hA7, 8'hA3, 8'hA1, 8'hA4};
`endif
        do_conv(8'h5A, lat, res, bn, sn, ov, ed);
        n_checks++;
        if (res !== 8'h5A || lat != LAT) begin
            n_errors++; $display("FAIL p5a_conv: got %h at %0d expected 5a at %0d", res, lat, LAT);
        end
        n_checks++;
        if (ov != 0) begin n_errors++; $display("FAIL p5a_sw_overlap: got %0d expected 0", ov); end
`ifdef SAR_BBM_EN
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (log_sw[3 + 3*k] !== exp_sw[k] || log_swb[3 + 3*k] !== exp_swb[k]) begin
                n_errors++;
                $display("FAIL p5a_gap%0d: got sw/swb %h/%h expected %h/%h", k,
                         log_sw[3 + 3*k], log_swb[3 + 3*k], exp_sw[k], exp_swb[k]);
            end
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_err();
        test_rdy();
        test_async_reset();
        test_pattern_5a();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
